// File: rtl/ads1256_spi_responder_if.sv
// rtl/ads1256_spi_responder_if.sv - SPI pins and conversion signals of the ADS1256 responder
interface ads1256_spi_responder_if;
  logic        SCLK_i;
  logic        CS_L_i;
  logic        MOSI_i;
  logic        MISO_o;
  logic        MISO_oe_o;
  logic        DRDY_L_o;
  logic        rdatac_o;
  logic [23:0] sample_i;

  modport master (output SCLK_i, CS_L_i, MOSI_i, sample_i,
                  input  MISO_o, MISO_oe_o, DRDY_L_o, rdatac_o);
  modport slave  (input  SCLK_i, CS_L_i, MOSI_i, sample_i,
                  output MISO_o, MISO_oe_o, DRDY_L_o, rdatac_o);
endinterface

// File: rtl/ads1256_spi_responder.sv
// rtl/ads1256_spi_responder.sv - ADS1256 SPI responder: command decode, register file, DRDY cadence
module ads1256_spi_responder #(
  parameter int SYNC_STAGES      = 2,
  parameter int DRDY_PERIOD      = 3333,
  parameter int DRDY_HIGH_CYCLES = 10,
  parameter int CAL_CYCLES       = 1000
) (
  input logic                    clock_i,
  input logic                    reset_i,
  ads1256_spi_responder_if.slave spi
);
  localparam int DW = $clog2(DRDY_PERIOD);
  localparam int CW = (CAL_CYCLES > 1) ? $clog2(CAL_CYCLES) : 1;
  localparam logic [DW-1:0] DRDY_LAST = DW'(DRDY_PERIOD - 1);
  localparam logic [DW-1:0] DRDY_RISE = DW'(DRDY_PERIOD - DRDY_HIGH_CYCLES);
  localparam logic [CW-1:0] CAL_LAST  = CW'(CAL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARG, WDATA, TX} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_d, sclk_s, cs_s, mosi_s, rise, fall;
  logic [2:0]    bit_cnt;
  logic [6:0]    rx_sh;
  logic [7:0]    rx_byte;
  logic [23:0]   tx_sh, data_q;
  logic [7:0]    tx_cnt;
  logic [4:0]    addr, n_plus;
  logic [3:0]    wr_left;
  logic [DW-1:0] drdy_cnt;
  logic [CW-1:0] cal_cnt;
  logic [2:0]    status_w;
  logic [7:0]    regs [1:10];
  logic tx_rreg, tx_data, arg_wreg, cal_busy, armed, rdatac, drdy_l, miso, miso_oe;
  logic byte_done, cmd_ok, rdc_ok, tx_end, start_stream;
  logic do_rdata, do_rdatac, do_sdatac, do_reset, do_sync, do_cal, do_regcmd, do_write;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign rx_byte = {rx_sh, mosi_s};
  assign n_plus  = {1'b0, rx_byte[3:0]} + 5'd1;

  // Full decode only outside continuous-read mode; in it just SDATAC/RESET are honoured.
  assign byte_done    = fall & ~cs_s & (bit_cnt == 3'd7);
  assign cmd_ok       = byte_done & (state == IDLE) & ~rdatac;
  assign rdc_ok       = byte_done & rdatac & ((state == IDLE) | (state == TX));
  assign do_rdata     = cmd_ok & (rx_byte == 8'h01) & ~cal_busy;
  assign do_rdatac    = cmd_ok & (rx_byte == 8'h03);
  assign do_sdatac    = (cmd_ok | rdc_ok) & (rx_byte == 8'h0F);
  assign do_reset     = (cmd_ok | rdc_ok) & (rx_byte == 8'hFE);
  assign do_sync      = cmd_ok & (rx_byte == 8'hFC);
  assign do_cal       = cmd_ok & (rx_byte[7:2] == 6'b111100);
  assign do_regcmd    = cmd_ok & ((rx_byte[7:4] == 4'h1) | (rx_byte[7:4] == 4'h5));
  assign do_write     = byte_done & (state == WDATA);
  assign tx_end       = (state == TX) & ~cs_s & fall & (tx_cnt == 8'd0);
  assign start_stream = armed & ~cs_s & ~sclk_s & (bit_cnt == 3'd0) & (state == IDLE);

  function automatic logic [7:0] reg_rd(input logic [4:0] a);
    if (a == 5'd0)       return {4'h3, status_w, drdy_l};
    else if (a <= 5'd10) return regs[a[3:0]];
    else                 return 8'h00;
  endfunction

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.CS_L_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI_i};
      sclk_d    <= sclk_s;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cs_s) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (do_rdata || start_stream) state_next = TX;
                 else if (do_regcmd)            state_next = ARG;
        ARG:     if (byte_done) state_next = arg_wreg ? WDATA : TX;
        WDATA:   if (byte_done && wr_left == 4'd0) state_next = IDLE;
        TX:      if (tx_end) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      bit_cnt <= '0;  rx_sh <= '0;  tx_sh <= '0;  tx_cnt <= '0;  data_q <= '0;
      addr <= '0;  wr_left <= '0;  drdy_cnt <= '0;  cal_cnt <= '0;
      tx_rreg <= 1'b0;  tx_data <= 1'b0;  arg_wreg <= 1'b0;  cal_busy <= 1'b0;
      armed <= 1'b0;  rdatac <= 1'b0;  drdy_l <= 1'b1;  miso <= 1'b0;  miso_oe <= 1'b0;
    end else begin
      miso_oe <= ~cs_s;
      if (cal_busy) begin
        drdy_l   <= 1'b1;
        drdy_cnt <= '0;
        cal_cnt  <= cal_cnt + CW'(1);
        if (cal_cnt == CAL_LAST) cal_busy <= 1'b0;
      end else if (drdy_cnt == DRDY_LAST) begin
        drdy_cnt <= '0;
        data_q   <= spi.sample_i;
        drdy_l   <= 1'b0;
        if (rdatac && state != TX) armed <= 1'b1;
      end else begin
        drdy_cnt <= drdy_cnt + DW'(1);
        if (drdy_cnt == DRDY_RISE) drdy_l <= 1'b1;
      end

      if (cs_s) begin
        bit_cnt <= '0;
        miso    <= 1'b0;
      end else if (fall) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sh   <= {rx_sh[5:0], mosi_s};
      end

      if (start_stream || do_rdata) begin
        tx_sh   <= data_q;
        tx_cnt  <= 8'd24;
        tx_data <= 1'b1;
        tx_rreg <= 1'b0;
        armed   <= 1'b0;
      end
      if (do_rdatac) begin rdatac <= 1'b1; armed <= 1'b0; end
      if (do_sdatac) begin rdatac <= 1'b0; armed <= 1'b0; end
      if (do_reset)  begin rdatac <= 1'b0; armed <= 1'b0; drdy_cnt <= '0; end
      if (do_sync)   drdy_cnt <= '0;
      if (do_cal)    begin cal_busy <= 1'b1; cal_cnt <= '0; drdy_l <= 1'b1; end
      if (do_regcmd) begin addr <= {1'b0, rx_byte[3:0]}; arg_wreg <= rx_byte[6]; end
      if (state == ARG && byte_done) begin
        wr_left <= rx_byte[3:0];
        if (!arg_wreg) begin
          tx_sh   <= {reg_rd(addr), 16'h0000};
          tx_cnt  <= {n_plus, 3'b000};
          tx_data <= 1'b0;
          tx_rreg <= 1'b1;
        end
      end
      if (do_write) begin
        addr    <= addr + 5'd1;
        wr_left <= wr_left - 4'd1;
      end
      if (state == TX && !cs_s && rise && tx_cnt != 8'd0) begin
        miso   <= tx_sh[23];
        tx_sh  <= {tx_sh[22:0], 1'b0};
        tx_cnt <= tx_cnt - 8'd1;
        // Last bit of an RREG byte: queue the next register behind it.
        if (tx_rreg && tx_cnt[2:0] == 3'd1) begin
          tx_sh[23:16] <= reg_rd(addr + 5'd1);
          addr         <= addr + 5'd1;
        end
      end
      if (tx_end) begin
        miso <= 1'b0;
        if (tx_data) drdy_l <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || do_reset) begin
      status_w <= '0;
      for (int i = 1; i <= 10; i++) regs[i] <= 8'h00;
      regs[1] <= 8'h01;
      regs[2] <= 8'h20;
      regs[3] <= 8'hF0;
      regs[4] <= 8'hE0;
    end else if (do_write) begin
      if (addr == 5'd0)       status_w <= rx_byte[3:1];
      else if (addr <= 5'd10) regs[addr[3:0]] <= rx_byte;
    end
  end

  assign spi.MISO_o    = miso;
  assign spi.MISO_oe_o = miso_oe;
  assign spi.DRDY_L_o  = drdy_l;
  assign spi.rdatac_o  = rdatac;
endmodule

// File: tb/tb_ads1256_spi_responder.sv
// tb/tb_ads1256_spi_responder.sv - directed bench for the ADS1256 SPI responder
module tb_ads1256_spi_responder;
  localparam int HP = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ads1256_spi_responder_if bus();

  ads1256_spi_responder dut (
    .clock_i (clk),
    .reset_i (rst),
    .spi     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    bus.SCLK_i = 1'b1;
    bus.MOSI_i = b;
    tick(HP);
    r = bus.MISO_o;
    bus.SCLK_i = 1'b0;
    tick(HP);
  endtask

  task automatic xfer(input logic [7:0] t, output logic [7:0] r);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(t[i], b);
      r[i] = b;
    end
  endtask

  task automatic cs_low();
    bus.CS_L_i = 1'b0;
    tick(HP);
  endtask

  task automatic cs_high();
    tick(HP);
    bus.CS_L_i = 1'b1;
    tick(HP);
  endtask

  task automatic wait_drdy(input logic level, input string nm);
    int n = 0;
    while (bus.DRDY_L_o !== level && n < 8000) begin
      tick(1);
      n++;
    end
    checks++;
    if (bus.DRDY_L_o !== level) begin
      errors++;
      $display("FAIL %s timeout drdy=%b want %b", nm, bus.DRDY_L_o, level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (bus.DRDY_L_o !== 1'b1)  begin errors++; $display("FAIL reset_drdy got %b want 1", bus.DRDY_L_o); end
    checks++; if (bus.MISO_oe_o !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", bus.MISO_oe_o); end
    checks++; if (bus.MISO_o !== 1'b0)    begin errors++; $display("FAIL reset_miso got %b want 0", bus.MISO_o); end
    checks++; if (bus.rdatac_o !== 1'b0)  begin errors++; $display("FAIL reset_rdatac got %b want 0", bus.rdatac_o); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_rreg_status();
    logic [7:0] r;
    cs_low();
    checks++; if (bus.MISO_oe_o !== 1'b1) begin errors++; $display("FAIL cs_oe got %b want 1", bus.MISO_oe_o); end
    xfer(8'h10, r);
    xfer(8'h00, r);
    xfer(8'h00, r);
    cs_high();
    checks++; if ((r & 8'hFE) !== 8'h30) begin errors++; $display("FAIL status_hi got %h want 30", r & 8'hFE); end
    checks++; if (r[0] !== 1'b1) begin errors++; $display("FAIL status_drdy got %b want 1", r[0]); end
  endtask

  task automatic test_rdata();
    logic [7:0] r0, r1, r2;
    bus.sample_i = 24'hA5C3E7;
    wait_drdy(1'b0, "rdata_drdy_low");
    cs_low();
    xfer(8'h01, r0);
    xfer(8'h00, r0);
    xfer(8'h00, r1);
    checks++; if (bus.DRDY_L_o !== 1'b0) begin errors++; $display("FAIL rdata_drdy_mid got %b want 0", bus.DRDY_L_o); end
    xfer(8'h00, r2);
    checks++; if (bus.DRDY_L_o !== 1'b1) begin errors++; $display("FAIL rdata_drdy_after got %b want 1", bus.DRDY_L_o); end
    cs_high();
    checks++; if ({r0, r1, r2} !== 24'hA5C3E7) begin errors++; $display("FAIL rdata_value got %h want a5c3e7", {r0, r1, r2}); end
  endtask

  task automatic test_cal_abort();
    logic [7:0] r;
    logic b;
    int n = 0;
    cs_low();
    xfer(8'hF0, r);
    cs_high();
    checks++; if (bus.DRDY_L_o !== 1'b1) begin errors++; $display("FAIL cal_drdy_high got %b want 1", bus.DRDY_L_o); end
    while (bus.DRDY_L_o !== 1'b0 && n < 6000) begin
      tick(1);
      n++;
    end
    checks++; if (n < 4290 || n > 4350) begin errors++; $display("FAIL cal_to_drdy got %0d cycles want about 4320", n); end
    cs_low();
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    cs_high();
    cs_low();
    xfer(8'h00, r);
    xfer(8'h13, r);
    xfer(8'h00, r);
    xfer(8'h00, r);
    cs_high();
    checks++; if (r !== 8'hF0) begin errors++; $display("FAIL abort_drate got %h want f0", r); end
  endtask

  task automatic test_wreg();
    logic [7:0] r0, r1;
    cs_low();
    xfer(8'h52, r0); xfer(8'h01, r0); xfer(8'h11, r0); xfer(8'h22, r0);
    xfer(8'h5A, r0); xfer(8'h00, r0); xfer(8'h77, r0);
    xfer(8'h50, r0); xfer(8'h00, r0); xfer(8'hFF, r0);
    cs_high();
    cs_low();
    xfer(8'h12, r0); xfer(8'h01, r0); xfer(8'h00, r0); xfer(8'h00, r1);
    cs_high();
    checks++; if (r0 !== 8'h11) begin errors++; $display("FAIL wreg_adcon got %h want 11", r0); end
    checks++; if (r1 !== 8'h22) begin errors++; $display("FAIL wreg_drate got %h want 22", r1); end
    cs_low();
    xfer(8'h1A, r0); xfer(8'h01, r0); xfer(8'h00, r0); xfer(8'h00, r1);
    cs_high();
    checks++; if (r0 !== 8'h77) begin errors++; $display("FAIL wreg_fsc2 got %h want 77", r0); end
    checks++; if (r1 !== 8'h00) begin errors++; $display("FAIL rreg_past_end got %h want 00", r1); end
    cs_low();
    xfer(8'h10, r0); xfer(8'h00, r0); xfer(8'h00, r0);
    xfer(8'hFE, r1);
    xfer(8'h12, r1); xfer(8'h00, r1); xfer(8'h00, r1);
    cs_high();
    checks++; if ((r0 & 8'hFE) !== 8'h3E) begin errors++; $display("FAIL status_write got %h want 3e", r0 & 8'hFE); end
    checks++; if (r1 !== 8'h20) begin errors++; $display("FAIL soft_reset_adcon got %h want 20", r1); end
  endtask

  task automatic test_rdatac();
    logic [7:0] r0, r1, r2;
    cs_low();
    xfer(8'h03, r0);
    cs_high();
    checks++; if (bus.rdatac_o !== 1'b1) begin errors++; $display("FAIL rdatac_on got %b want 1", bus.rdatac_o); end
    for (int k = 1; k <= 3; k++) begin
      bus.sample_i = 24'(k);
      wait_drdy(1'b1, "rdatac_drdy_high");
      wait_drdy(1'b0, "rdatac_drdy_low");
      cs_low();
      xfer(8'h00, r0); xfer(8'h00, r1); xfer(8'h00, r2);
      cs_high();
      checks++;
      if ({r0, r1, r2} !== 24'(k)) begin
        errors++;
        $display("FAIL rdatac_value%0d got %h want %h", k, {r0, r1, r2}, 24'(k));
      end
    end
    cs_low();
    xfer(8'h0F, r0);
    cs_high();
    checks++; if (bus.rdatac_o !== 1'b0) begin errors++; $display("FAIL sdatac got %b want 0", bus.rdatac_o); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    logic b;
    cs_low();
    xfer(8'h51, r); xfer(8'h00, r); xfer(8'h5A, r);
    xfer(8'h03, r);
    cs_high();
    checks++; if (bus.rdatac_o !== 1'b1) begin errors++; $display("FAIL mid_rdatac_on got %b want 1", bus.rdatac_o); end
    wait_drdy(1'b1, "mid_drdy_high");
    wait_drdy(1'b0, "mid_drdy_low");
    cs_low();
    for (int i = 0; i < 10; i++) spi_bit(1'b0, b);
    rst = 1'b1;
    tick(1);
    checks++; if (bus.MISO_oe_o !== 1'b0) begin errors++; $display("FAIL mid_oe got %b want 0", bus.MISO_oe_o); end
    checks++; if (bus.rdatac_o !== 1'b0)  begin errors++; $display("FAIL mid_rdatac got %b want 0", bus.rdatac_o); end
    checks++; if (bus.DRDY_L_o !== 1'b1)  begin errors++; $display("FAIL mid_drdy got %b want 1", bus.DRDY_L_o); end
    rst = 1'b0;
    cs_high();
    cs_low();
    xfer(8'h11, r); xfer(8'h00, r); xfer(8'h00, r);
    cs_high();
    checks++; if (r !== 8'h01) begin errors++; $display("FAIL mid_mux_default got %h want 01", r); end
  endtask

  initial begin
    bus.SCLK_i   = 1'b0;
    bus.CS_L_i   = 1'b1;
    bus.MOSI_i   = 1'b0;
    bus.sample_i = 24'h000000;
    test_reset();
    test_rreg_status();
    test_rdata();
    test_cal_abort();
    test_wreg();
    test_rdatac();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
